case_match_engine: RTL and testbench

//  Registered, parametrised 4-state pattern matcher implementing case/casez/casex priority semantics.

---
 rtl/case_match_engine_pkg.sv | 12 +
 rtl/case_match_item_cmp.sv | 31 +++
 rtl/case_match_engine.sv | 87 ++++++++
 tb/tb_case_match_engine.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/case_match_engine_pkg.sv
// case_match_engine_pkg: mode encodings and the width helper shared by the matcher files
package case_match_engine_pkg;
  localparam logic [1:0] MODE_CASE  = 2'd0;
  localparam logic [1:0] MODE_CASEZ = 2'd1;
  localparam logic [1:0] MODE_CASEX = 2'd2;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r == 0) ? 1 : r;
  endfunction
endpackage

// File: rtl/case_match_item_cmp.sv
// case_match_item_cmp: single-item 4-state comparator with case/casez/casex bit rules
module case_match_item_cmp import case_match_engine_pkg::*; #(
  parameter int SEL_W = 3
) (
  input  logic [SEL_W-1:0] sel,
  input  logic [SEL_W-1:0] pat,
  input  logic [1:0]       mode,
  output logic             match
);
  logic [SEL_W-1:0] ok;
  for (genvar b = 0; b < SEL_W; b++) begin : g_bit
    logic sz, pz;
    // casez treats a z selector bit as a wildcard, so a match against 1 that is not a real 1 means z
    always_comb begin
      sz = 1'b0;
      pz = 1'b0;
      casez (sel[b])
        1'b1: sz = (sel[b] !== 1'b1);
        default: ;
      endcase
      casez (pat[b])
        1'b1: pz = (pat[b] !== 1'b1);
        default: ;
      endcase
    end
    assign ok[b] = (sel[b] === pat[b])
                || (mode == MODE_CASEZ && (sz || pz))
                || (mode == MODE_CASEX && ($isunknown(sel[b]) || $isunknown(pat[b])));
  end
  assign match = &ok;
endmodule

// File: rtl/case_match_engine.sv
// case_match_engine: registered priority matcher over a loadable table of 4-state patterns
module case_match_engine import case_match_engine_pkg::*; #(
  parameter int SEL_W     = 3,
  parameter int DATA_W    = 8,
  parameter int NUM_ITEMS = 4,
  parameter int CNT_W     = 16,
  localparam int AW       = clog2(NUM_ITEMS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [SEL_W-1:0]  in_sel,
  input  logic              cfg_we,
  input  logic [AW-1:0]     cfg_addr,
  input  logic [SEL_W-1:0]  cfg_pat,
  input  logic [DATA_W-1:0] cfg_data,
  input  logic              cfg_en,
  input  logic              cfg_dflt_we,
  input  logic              cfg_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_hit,
  output logic [AW-1:0]     out_index,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt,
  output logic [CNT_W-1:0]  xsel_cnt
);
  logic [SEL_W-1:0]     pat  [NUM_ITEMS];
  logic [DATA_W-1:0]    data [NUM_ITEMS];
  logic [NUM_ITEMS-1:0] en, match;
  logic [DATA_W-1:0]    dflt;
  logic                 hit, acc;
  logic [AW-1:0]        idx;
  assign in_ready = !out_valid || out_ready;
  assign acc = (in_valid === 1'b1) && in_ready;
  for (genvar i = 0; i < NUM_ITEMS; i++) begin : g_item
    logic m;
    case_match_item_cmp #(.SEL_W(SEL_W)) u_cmp (.sel(in_sel), .pat(pat[i]), .mode(mode), .match(m));
    assign match[i] = en[i] && m;
  end
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_ITEMS - 1; i >= 0; i--)
      if (match[i]) begin
        hit = 1'b1;
        idx = AW'(i);
      end
  end
  always_ff @(posedge clk)
    for (int i = 0; i < NUM_ITEMS; i++)
      if (cfg_we && cfg_addr == AW'(i)) begin
        pat[i]  <= cfg_pat;
        data[i] <= cfg_data;
      end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      en   <= '0;
      dflt <= '1;
    end else begin
      for (int i = 0; i < NUM_ITEMS; i++)
        if (cfg_clr) en[i] <= 1'b0;
        else if (cfg_we && cfg_addr == AW'(i)) en[i] <= cfg_en;
      if (cfg_dflt_we) dflt <= cfg_data;
    end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_hit   <= 1'b0;
      out_index <= '0;
      out_data  <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
      xsel_cnt  <= '0;
    end else if (acc) begin
      out_valid <= 1'b1;
      out_hit   <= hit;
      out_index <= idx;
      out_data  <= hit ? data[idx] : dflt;
      if (hit && hit_cnt != '1) hit_cnt <= hit_cnt + CNT_W'(1);
      if (!hit && miss_cnt != '1) miss_cnt <= miss_cnt + CNT_W'(1);
      if ($isunknown(in_sel) && xsel_cnt != '1) xsel_cnt <= xsel_cnt + CNT_W'(1);
    end else if (out_ready) out_valid <= 1'b0;
endmodule

// File: tb/tb_case_match_engine.sv
// tb_case_match_engine: directed checks of matching modes, table access, handshake, reset and counters
module tb_case_match_engine;
  logic clk, rst_n, in_valid, in_ready, cfg_we, cfg_en, cfg_dflt_we, cfg_clr;
  logic out_valid, out_ready, out_hit;
  logic [1:0] mode, cfg_addr, out_index;
  logic [2:0] in_sel, cfg_pat;
  logic [7:0] cfg_data, out_data;
  logic [15:0] hit_cnt, miss_cnt, xsel_cnt;
  logic v2, ir2, ov2, oh2;
  logic [1:0] oi2, hc2, mc2, xc2;
  logic [7:0] od2;
  logic xprobe, four_state;
  int tests, fails, eh, em, ex;

  case_match_engine dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_pat(cfg_pat), .cfg_data(cfg_data), .cfg_en(cfg_en),
    .cfg_dflt_we(cfg_dflt_we), .cfg_clr(cfg_clr), .out_valid(out_valid), .out_ready(out_ready),
    .out_hit(out_hit), .out_index(out_index), .out_data(out_data),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt), .xsel_cnt(xsel_cnt));

  case_match_engine #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(v2), .in_ready(ir2), .in_sel(in_sel),
    .cfg_we(1'b0), .cfg_addr(2'd0), .cfg_pat(3'd0), .cfg_data(8'd0), .cfg_en(1'b0),
    .cfg_dflt_we(1'b0), .cfg_clr(1'b0), .out_valid(ov2), .out_ready(1'b1),
    .out_hit(oh2), .out_index(oi2), .out_data(od2),
    .hit_cnt(hc2), .miss_cnt(mc2), .xsel_cnt(xc2));

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic write(input logic [1:0] a, input logic [2:0] p, input logic [7:0] d, input logic e);
    cfg_we = 1; cfg_addr = a; cfg_pat = p; cfg_data = d; cfg_en = e;
    step;
    cfg_we = 0;
  endtask

  task automatic clear;
    cfg_clr = 1;
    step;
    cfg_clr = 0;
  endtask

  task automatic lookup(input logic [1:0] m, input logic [2:0] s);
    mode = m; in_sel = s; in_valid = 1; out_ready = 1;
    step;
    in_valid = 0;
  endtask

  task automatic test_reset;
    #3;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got=%b exp=0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_data got=%h exp=00", out_data); end
    tests++; if (out_hit !== 1'b0 || out_index !== 2'd0) begin fails++; $display("FAIL rst_hit_idx got=%b/%0d exp=0/0", out_hit, out_index); end
    tests++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0 || xsel_cnt !== 16'd0) begin fails++; $display("FAIL rst_cnt got=%0d/%0d/%0d exp=0/0/0", hit_cnt, miss_cnt, xsel_cnt); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rst_ready got=%b exp=1", in_ready); end
    @(negedge clk) rst_n = 1;
    @(negedge clk);
  endtask

  task automatic test_case;
    clear;
    write(2'd0, 3'b000, 8'h00, 1);
    write(2'd1, 3'b001, 8'h11, 1);
    write(2'd2, four_state ? 3'bxxx : 3'b110, 8'hAA, 1);
    lookup(2'd0, four_state ? 3'bxxx : 3'b110);
    eh++; if (four_state) ex++;
    tests++; if (out_valid !== 1 || out_hit !== 1 || out_index !== 2'd2 || out_data !== 8'hAA) begin fails++; $display("FAIL case_hit got=%b/%b/%0d/%h exp=1/1/2/AA", out_valid, out_hit, out_index, out_data); end
    lookup(2'd0, four_state ? 3'b01x : 3'b011);
    em++; if (four_state) ex++;
    tests++; if (out_hit !== 0 || out_index !== 2'd0 || out_data !== 8'hFF) begin fails++; $display("FAIL case_miss got=%b/%0d/%h exp=0/0/FF", out_hit, out_index, out_data); end
    tests++; if (xsel_cnt !== ex[15:0]) begin fails++; $display("FAIL case_xsel got=%0d exp=%0d", xsel_cnt, ex); end
    lookup(2'd0, 3'b001);
    eh++;
    tests++; if (out_hit !== 1 || out_index !== 2'd1 || out_data !== 8'h11) begin fails++; $display("FAIL case_idx1 got=%b/%0d/%h exp=1/1/11", out_hit, out_index, out_data); end
    tests++; if (hit_cnt !== eh[15:0] || miss_cnt !== em[15:0]) begin fails++; $display("FAIL case_cnt got=%0d/%0d exp=%0d/%0d", hit_cnt, miss_cnt, eh, em); end
  endtask

  task automatic test_casez;
    clear;
    write(2'd0, 3'b000, 8'h00, 1);
    write(2'd1, four_state ? 3'b0zz : 3'b010, 8'h33, 1);
    lookup(2'd1, 3'b010);
    eh++;
    tests++; if (out_hit !== 1 || out_index !== 2'd1 || out_data !== 8'h33) begin fails++; $display("FAIL casez_010 got=%b/%0d/%h exp=1/1/33", out_hit, out_index, out_data); end
    if (four_state) begin
      lookup(2'd1, 3'b0xx);
      eh++; ex++;
      tests++; if (out_hit !== 1 || out_index !== 2'd1 || out_data !== 8'h33) begin fails++; $display("FAIL casez_0xx got=%b/%0d/%h exp=1/1/33", out_hit, out_index, out_data); end
      lookup(2'd1, 3'bx10);
      em++; ex++;
    end else begin
      lookup(2'd1, 3'b110);
      em++;
    end
    tests++; if (out_hit !== 0 || out_data !== 8'hFF) begin fails++; $display("FAIL casez_miss got=%b/%h exp=0/FF", out_hit, out_data); end
    tests++; if (miss_cnt !== em[15:0] || xsel_cnt !== ex[15:0]) begin fails++; $display("FAIL casez_cnt got=%0d/%0d exp=%0d/%0d", miss_cnt, xsel_cnt, em, ex); end
  endtask

  task automatic test_casex;
    clear;
    write(2'd0, 3'b000, 8'h00, 1);
    write(2'd1, four_state ? 3'b0xx : 3'b011, 8'h22, 1);
    lookup(2'd2, four_state ? 3'bz00 : 3'b000);
    eh++; if (four_state) ex++;
    tests++; if (out_hit !== 1 || out_index !== 2'd0 || out_data !== 8'h00) begin fails++; $display("FAIL casex_prio got=%b/%0d/%h exp=1/0/00", out_hit, out_index, out_data); end
    lookup(2'd2, 3'b011);
    eh++;
    tests++; if (out_hit !== 1 || out_index !== 2'd1 || out_data !== 8'h22) begin fails++; $display("FAIL casex_011 got=%b/%0d/%h exp=1/1/22", out_hit, out_index, out_data); end
    tests++; if (hit_cnt !== eh[15:0]) begin fails++; $display("FAIL casex_cnt got=%0d exp=%0d", hit_cnt, eh); end
  endtask

  task automatic test_cfg_access;
    cfg_we = 1; cfg_addr = 2'd0; cfg_pat = 3'b000; cfg_data = 8'h5C; cfg_en = 1;
    mode = 2'd0; in_sel = 3'b000; in_valid = 1; out_ready = 1;
    step;
    cfg_we = 0; in_valid = 0; eh++;
    tests++; if (out_hit !== 1 || out_data !== 8'h00) begin fails++; $display("FAIL cfg_same_cycle got=%b/%h exp=1/00", out_hit, out_data); end
    lookup(2'd0, 3'b000);
    eh++;
    tests++; if (out_data !== 8'h5C) begin fails++; $display("FAIL cfg_new_data got=%h exp=5C", out_data); end
    cfg_clr = 1; cfg_we = 1; cfg_addr = 2'd0; cfg_pat = 3'b000; cfg_data = 8'h77; cfg_en = 1;
    step;
    cfg_clr = 0; cfg_we = 0;
    lookup(2'd0, 3'b000);
    em++;
    tests++; if (out_hit !== 0 || out_data !== 8'hFF) begin fails++; $display("FAIL cfg_clr_prio got=%b/%h exp=0/FF", out_hit, out_data); end
    cfg_dflt_we = 1; cfg_data = 8'h5A;
    step;
    cfg_dflt_we = 0;
    lookup(2'd3, 3'b101);
    em++;
    tests++; if (out_hit !== 0 || out_data !== 8'h5A) begin fails++; $display("FAIL cfg_default got=%b/%h exp=0/5A", out_hit, out_data); end
  endtask

  task automatic test_back_to_back;
    write(2'd0, 3'b000, 8'h00, 1);
    write(2'd1, 3'b001, 8'h11, 1);
    out_ready = 1;
    step;
    out_ready = 0; mode = 2'd0; in_sel = 3'b000; in_valid = 1;
    step;
    in_sel = 3'b001;
    for (int c = 0; c < 3; c++) begin
      tests++; if (in_ready !== 0) begin fails++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, in_ready); end
      tests++; if (out_valid !== 1 || out_index !== 2'd0 || out_data !== 8'h00) begin fails++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%h exp=1/0/00", c, out_valid, out_index, out_data); end
      step;
    end
    out_ready = 1;
    step;
    in_valid = 0; eh += 2;
    tests++; if (out_valid !== 1 || out_index !== 2'd1 || out_data !== 8'h11) begin fails++; $display("FAIL bp_second got=%b/%0d/%h exp=1/1/11", out_valid, out_index, out_data); end
    step;
    tests++; if (out_valid !== 0) begin fails++; $display("FAIL bp_no_dup got=%b exp=0", out_valid); end
    tests++; if (hit_cnt !== eh[15:0]) begin fails++; $display("FAIL bp_cnt got=%0d exp=%0d", hit_cnt, eh); end
  endtask

  task automatic test_reset_mid;
    lookup(2'd0, 3'b000);
    out_ready = 0;
    rst_n = 0;
    #1;
    tests++; if (out_valid !== 0 || out_data !== 8'h00) begin fails++; $display("FAIL rstmid_out got=%b/%h exp=0/00", out_valid, out_data); end
    tests++; if (hit_cnt !== 16'd0 || miss_cnt !== 16'd0) begin fails++; $display("FAIL rstmid_cnt got=%0d/%0d exp=0/0", hit_cnt, miss_cnt); end
    #2 rst_n = 1;
    eh = 0; em = 0; ex = 0;
    lookup(2'd0, 3'b000);
    em++;
    tests++; if (out_valid !== 1 || out_hit !== 0 || out_data !== 8'hFF) begin fails++; $display("FAIL rstmid_after got=%b/%b/%h exp=1/0/FF", out_valid, out_hit, out_data); end
    tests++; if (miss_cnt !== em[15:0]) begin fails++; $display("FAIL rstmid_miss got=%0d exp=%0d", miss_cnt, em); end
  endtask

  task automatic test_saturation;
    mode = 2'd0; in_sel = 3'b010; v2 = 1;
    repeat (5) step;
    v2 = 0;
    tests++; if (mc2 !== 2'd3) begin fails++; $display("FAIL sat_miss got=%0d exp=3", mc2); end
    tests++; if (hc2 !== 2'd0 || xc2 !== 2'd0) begin fails++; $display("FAIL sat_hit_x got=%0d/%0d exp=0/0", hc2, xc2); end
    tests++; if (ov2 !== 1 || oh2 !== 0 || oi2 !== 2'd0 || od2 !== 8'hFF || ir2 !== 1) begin fails++; $display("FAIL sat_out got=%b/%b/%0d/%h/%b exp=1/0/0/FF/1", ov2, oh2, oi2, od2, ir2); end
  endtask

  initial begin
    clk = 0; rst_n = 0; mode = 0; in_valid = 0; in_sel = 0; out_ready = 1; v2 = 0;
    cfg_we = 0; cfg_addr = 0; cfg_pat = 0; cfg_data = 0; cfg_en = 0; cfg_dflt_we = 0; cfg_clr = 0;
    tests = 0; fails = 0; eh = 0; em = 0; ex = 0;
    xprobe = 1'bx;
    four_state = (xprobe !== 1'b0) && (xprobe !== 1'b1);
    test_reset;
    test_case;
    test_casez;
    test_casex;
    test_cfg_access;
    test_back_to_back;
    test_reset_mid;
    test_saturation;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
